// File: rtl/c_module_pkg.sv
// Shared definitions for the lookup arbiter/controller.
// Holds the default parameter values and the owner-table entry type that
// records which requester allocated a given lookup ID.
package c_module_pkg;

  localparam int NUM_REQ_DEF = 4;   // lookup requesters
  localparam int ID_W_DEF    = 4;   // request ID width (16 outstanding IDs)
  localparam int INFO_W_DEF  = 64;  // lookup info width
  localparam int RSLT_W_DEF  = 32;  // lookup result width

  // Owner index storage is sized generously so NUM_REQ can be overridden
  // (up to 256 requesters) without touching the package.
  localparam int OWNER_W = 8;

  typedef struct packed {
    logic [OWNER_W-1:0] idx;  // requester that owns the ID
  } owner_entry_t;

endpackage

// File: rtl/lkp_rr_arb.sv
// Round-robin arbiter.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   req      : request vector
//   adv      : advance the pointer past the current winner (request accepted)
//   grant    : one-hot grant (zero when no request)
//   idx      : index of the granted requester
// The search starts at the pointer; the pointer moves to winner+1 only when
// adv is high, so a refused grant is offered again to the same requester.
module lkp_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] ptr_reg;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int cand;
      cand = int'(ptr_reg) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (adv) begin
      ptr_reg <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/lkp_arb_ctrl.sv
// Lookup arbiter/controller.
// Arbitrates NUM_REQ requesters onto a single lookup channel towards A,
// tagging each accepted request with the lowest free ID, and routes A's
// responses (any order) back to the requester that owns the ID.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_vld/req_info/req_rdy      : per-requester request handshake
//   c2a_lkp_vld/info/req_id       : registered request slot towards A
//   a2c_lkp_rdy                   : A accepts the slot contents
//   a2c_lkp_rsp_vld/rsp_id/rslt   : responses from A (no backpressure)
//   rsp_vld/rsp_rslt/rsp_req_id   : registered one-hot response to owner
//   outstanding                   : number of allocated IDs
//   err_unalloc                   : sticky, response for an unallocated ID
module lkp_arb_ctrl
  import c_module_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int INFO_W  = INFO_W_DEF,
  parameter int RSLT_W  = RSLT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*INFO_W-1:0] req_info,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic                      c2a_lkp_vld,
  output logic [INFO_W-1:0]         c2a_lkp_info,
  output logic [ID_W-1:0]           c2a_lkp_req_id,
  input  logic                      a2c_lkp_rdy,
  input  logic                      a2c_lkp_rsp_vld,
  input  logic [ID_W-1:0]           a2c_lkp_rsp_id,
  input  logic [RSLT_W-1:0]         a2c_lkp_rslt,
  output logic [NUM_REQ-1:0]        rsp_vld,
  output logic [RSLT_W-1:0]         rsp_rslt,
  output logic [ID_W-1:0]           rsp_req_id,
  output logic [ID_W:0]             outstanding,
  output logic                      err_unalloc
);

  localparam int NUM_IDS = 1 << ID_W;
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_IDS-1:0] busy_reg, busy_next;
  owner_entry_t       owner_reg [NUM_IDS];
  logic [ID_W:0]      outstanding_reg;
  logic               c2a_vld_reg;
  logic [INFO_W-1:0]  c2a_info_reg;
  logic [ID_W-1:0]    c2a_id_reg;
  logic [NUM_REQ-1:0] rsp_vld_reg;
  logic [RSLT_W-1:0]  rsp_rslt_reg;
  logic [ID_W-1:0]    rsp_id_reg;
  logic               err_reg;

  logic               slot_free, id_avail, accept_ok, accept;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic [INFO_W-1:0]  win_info;
  logic [ID_W-1:0]    free_id;
  logic               rsp_hit, rsp_miss;
  logic [OWNER_W-1:0] rsp_owner;
  logic [NUM_REQ-1:0] rsp_onehot;

  // The slot can take a new request if empty or being drained this cycle.
  assign slot_free = !c2a_vld_reg || a2c_lkp_rdy;
  assign id_avail  = ~&busy_reg;
  assign accept_ok = slot_free && id_avail && !rst;
  assign req_rdy   = accept_ok ? grant : '0;
  assign accept    = accept_ok && (|grant);
  assign win_info  = req_info[win_idx*INFO_W +: INFO_W];

  lkp_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_vld),
    .adv   (accept),
    .grant (grant),
    .idx   (win_idx)
  );

  // Lowest-numbered free ID; scanning downwards leaves the lowest hit last.
  always_comb begin
    free_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!busy_reg[i]) free_id = ID_W'(i);
    end
  end

  // Responses are judged against the pre-update bitmap, so an ID freed by a
  // response only becomes allocatable once busy_reg has been updated.
  assign rsp_hit   = a2c_lkp_rsp_vld &&  busy_reg[a2c_lkp_rsp_id];
  assign rsp_miss  = a2c_lkp_rsp_vld && !busy_reg[a2c_lkp_rsp_id];
  assign rsp_owner = owner_reg[a2c_lkp_rsp_id].idx;

  always_comb begin
    rsp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_onehot[i] = (rsp_owner == OWNER_W'(i));
    end
  end

  // Allocation always picks a free ID and a hit always targets a busy one,
  // so the set and clear below never collide.
  always_comb begin
    busy_next = busy_reg;
    if (accept)  busy_next[free_id]        = 1'b1;
    if (rsp_hit) busy_next[a2c_lkp_rsp_id] = 1'b0;
  end

  for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_owner
    always_ff @(posedge clk) begin
      if (rst) begin
        owner_reg[gi] <= '0;
      end else if (accept && free_id == ID_W'(gi)) begin
        owner_reg[gi] <= '{idx: OWNER_W'(win_idx)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg        <= '0;
      outstanding_reg <= '0;
      c2a_vld_reg     <= 1'b0;
      c2a_info_reg    <= '0;
      c2a_id_reg      <= '0;
      rsp_vld_reg     <= '0;
      rsp_rslt_reg    <= '0;
      rsp_id_reg      <= '0;
      err_reg         <= 1'b0;
    end else begin
      busy_reg <= busy_next;

      case ({accept, rsp_hit})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
        default: ;
      endcase

      // Slot contents only change on a new acceptance, which keeps them
      // stable while A stalls.
      if (accept) begin
        c2a_vld_reg  <= 1'b1;
        c2a_info_reg <= win_info;
        c2a_id_reg   <= free_id;
      end else if (a2c_lkp_rdy) begin
        c2a_vld_reg  <= 1'b0;
      end

      rsp_vld_reg <= rsp_hit ? rsp_onehot : '0;
      if (rsp_hit) begin
        rsp_rslt_reg <= a2c_lkp_rslt;
        rsp_id_reg   <= a2c_lkp_rsp_id;
      end

      if (rsp_miss) err_reg <= 1'b1;
    end
  end

  assign c2a_lkp_vld    = c2a_vld_reg;
  assign c2a_lkp_info   = c2a_info_reg;
  assign c2a_lkp_req_id = c2a_id_reg;
  assign rsp_vld        = rsp_vld_reg;
  assign rsp_rslt       = rsp_rslt_reg;
  assign rsp_req_id     = rsp_id_reg;
  assign outstanding    = outstanding_reg;
  assign err_unalloc    = err_reg;

endmodule

// File: tb/tb_lkp_arb_ctrl.sv
// Testbench for lkp_arb_ctrl: directed scenarios drive stimulus and push
// expected c2a / response transactions into queues; a negedge monitor pops
// and compares whenever the DUT presents a transaction.
module tb_lkp_arb_ctrl;

  localparam int NR  = 4;
  localparam int IW  = 4;
  localparam int INW = 64;
  localparam int RW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_vld;
  logic [NR*INW-1:0] req_info;
  logic [NR-1:0]     req_rdy;
  logic              c2a_lkp_vld;
  logic [INW-1:0]    c2a_lkp_info;
  logic [IW-1:0]     c2a_lkp_req_id;
  logic              a2c_lkp_rdy;
  logic              a2c_lkp_rsp_vld;
  logic [IW-1:0]     a2c_lkp_rsp_id;
  logic [RW-1:0]     a2c_lkp_rslt;
  logic [NR-1:0]     rsp_vld;
  logic [RW-1:0]     rsp_rslt;
  logic [IW-1:0]     rsp_req_id;
  logic [IW:0]       outstanding;
  logic              err_unalloc;

  typedef struct packed {
    logic [INW-1:0] info;
    logic [IW-1:0]  id;
  } c2a_exp_t;

  typedef struct packed {
    logic [NR-1:0] vld;
    logic [RW-1:0] rslt;
    logic [IW-1:0] id;
  } rsp_exp_t;

  c2a_exp_t c2a_q[$];
  rsp_exp_t rsp_q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lkp_arb_ctrl #(
    .NUM_REQ (NR),
    .ID_W    (IW),
    .INFO_W  (INW),
    .RSLT_W  (RW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_vld         (req_vld),
    .req_info        (req_info),
    .req_rdy         (req_rdy),
    .c2a_lkp_vld     (c2a_lkp_vld),
    .c2a_lkp_info    (c2a_lkp_info),
    .c2a_lkp_req_id  (c2a_lkp_req_id),
    .a2c_lkp_rdy     (a2c_lkp_rdy),
    .a2c_lkp_rsp_vld (a2c_lkp_rsp_vld),
    .a2c_lkp_rsp_id  (a2c_lkp_rsp_id),
    .a2c_lkp_rslt    (a2c_lkp_rslt),
    .rsp_vld         (rsp_vld),
    .rsp_rslt        (rsp_rslt),
    .rsp_req_id      (rsp_req_id),
    .outstanding     (outstanding),
    .err_unalloc     (err_unalloc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_info(input int r, input logic [INW-1:0] v);
    req_info[r*INW +: INW] = v;
  endtask

  task automatic send_rsp(input logic [IW-1:0] id, input logic [RW-1:0] rslt);
    a2c_lkp_rsp_vld = 1'b1;
    a2c_lkp_rsp_id  = id;
    a2c_lkp_rslt    = rslt;
  endtask

  // Monitor: pops expected transactions as the DUT presents them.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (c2a_lkp_vld && a2c_lkp_rdy) begin
        if (c2a_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL c2a_unexpected: got info 0x%0h id %0d, expected none", c2a_lkp_info, c2a_lkp_req_id);
        end else begin
          c2a_exp_t e;
          e = c2a_q.pop_front();
          chk("c2a_info", 64'(c2a_lkp_info), 64'(e.info));
          chk("c2a_id", 64'(c2a_lkp_req_id), 64'(e.id));
          $display("c2a txn: info 0x%0h id %0d", c2a_lkp_info, c2a_lkp_req_id);
        end
      end
      if (rsp_vld != '0) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got vld %b id %0d, expected none", rsp_vld, rsp_req_id);
        end else begin
          rsp_exp_t r;
          r = rsp_q.pop_front();
          chk("rsp_vld", 64'(rsp_vld), 64'(r.vld));
          chk("rsp_rslt", 64'(rsp_rslt), 64'(r.rslt));
          chk("rsp_id", 64'(rsp_req_id), 64'(r.id));
          $display("rsp txn: vld %b rslt 0x%0h id %0d", rsp_vld, rsp_rslt, rsp_req_id);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_vld = '0;
    req_info = '0;
    a2c_lkp_rdy = 1'b1;
    a2c_lkp_rsp_vld = 1'b0;
    a2c_lkp_rsp_id = '0;
    a2c_lkp_rslt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c2a_vld", 64'(c2a_lkp_vld), 0);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_rsp_vld", 64'(rsp_vld), 0);
    chk("rst_err", 64'(err_unalloc), 0);
    chk("rst_req_rdy", 64'(req_rdy), 0);
    rst = 1'b0;
    tick();

    // Single request from requester 2, answered with 0x55.
    req_vld = 4'b0100;
    set_info(2, 64'hA5);
    #1 chk("single_rdy", 64'(req_rdy), 64'b0100);
    c2a_q.push_back('{info: 64'hA5, id: 4'd0});
    tick();
    req_vld = '0;
    chk("single_c2a_vld", 64'(c2a_lkp_vld), 1);
    chk("single_outstanding", 64'(outstanding), 1);
    send_rsp(4'd0, 32'h55);
    rsp_q.push_back('{vld: 4'b0100, rslt: 32'h55, id: 4'd0});
    tick();
    a2c_lkp_rsp_vld = 1'b0;
    chk("single_freed", 64'(outstanding), 0);
    tick();

    // Fairness: restart from pointer 0, all requesters valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < NR; r++) set_info(r, 64'(32'h10 + r));
    req_vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      #1 chk("fair_grant", 64'(req_rdy), 64'(exp_g));
      c2a_q.push_back('{info: 64'(32'h10 + (k % 4)), id: 4'(k)});
      tick();
    end
    req_vld = '0;
    #1 chk("fair_outstanding", 64'(outstanding), 5);
    tick();

    // Exhaustion: requester 1 takes IDs 5..15.
    req_vld = 4'b0010;
    for (int n = 0; n < 11; n++) begin
      set_info(1, 64'(32'h20 + n));
      #1 chk("exh_rdy", 64'(req_rdy), 64'b0010);
      c2a_q.push_back('{info: 64'(32'h20 + n), id: 4'(5 + n)});
      tick();
    end
    chk("exh_full_outstanding", 64'(outstanding), 16);
    chk("exh_full_rdy", 64'(req_rdy), 0);
    tick();
    chk("exh_slot_drained", 64'(c2a_lkp_vld), 0);
    send_rsp(4'd7, 32'h77);
    rsp_q.push_back('{vld: 4'b0010, rslt: 32'h77, id: 4'd7});
    #1 chk("exh_prefree_rdy", 64'(req_rdy), 0);
    tick();
    a2c_lkp_rsp_vld = 1'b0;
    set_info(1, 64'h3C);
    #1 chk("exh_reuse_rdy", 64'(req_rdy), 64'b0010);
    c2a_q.push_back('{info: 64'h3C, id: 4'd7});
    tick();
    req_vld = '0;
    chk("exh_reuse_outstanding", 64'(outstanding), 16);
    tick();

    // Out-of-order responses, then a response to a freed ID.
    send_rsp(4'd3, 32'h33);
    rsp_q.push_back('{vld: 4'b1000, rslt: 32'h33, id: 4'd3});
    tick();
    send_rsp(4'd0, 32'h30);
    rsp_q.push_back('{vld: 4'b0001, rslt: 32'h30, id: 4'd0});
    tick();
    send_rsp(4'd2, 32'h32);
    rsp_q.push_back('{vld: 4'b0100, rslt: 32'h32, id: 4'd2});
    tick();
    send_rsp(4'd9, 32'h99);
    rsp_q.push_back('{vld: 4'b0010, rslt: 32'h99, id: 4'd9});
    tick();
    chk("ooo_err_before", 64'(err_unalloc), 0);
    send_rsp(4'd9, 32'hEE);
    tick();
    a2c_lkp_rsp_vld = 1'b0;
    chk("err_flag", 64'(err_unalloc), 1);
    chk("err_no_rsp", 64'(rsp_vld), 0);
    chk("err_outstanding", 64'(outstanding), 12);
    tick();

    // Stall: A not ready for 5 cycles; free IDs are 0,2,3,9.
    a2c_lkp_rdy = 1'b0;
    req_vld = 4'b0001;
    set_info(0, 64'h40);
    #1 chk("stall_first_rdy", 64'(req_rdy), 64'b0001);
    c2a_q.push_back('{info: 64'h40, id: 4'd0});
    tick();
    for (int s = 0; s < 5; s++) begin
      chk("stall_rdy", 64'(req_rdy), 0);
      chk("stall_vld", 64'(c2a_lkp_vld), 1);
      chk("stall_info", 64'(c2a_lkp_info), 64'h40);
      chk("stall_id", 64'(c2a_lkp_req_id), 0);
      tick();
    end
    set_info(0, 64'h41);
    a2c_lkp_rdy = 1'b1;
    #1 chk("stall_release_rdy", 64'(req_rdy), 64'b0001);
    c2a_q.push_back('{info: 64'h41, id: 4'd2});
    tick();
    req_vld = '0;
    tick();
    chk("stall_outstanding", 64'(outstanding), 14);
    tick();

    // Reset mid-operation with 5 IDs outstanding and one request in the slot.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_vld = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      set_info(3, 64'(32'h50 + k));
      c2a_q.push_back('{info: 64'(32'h50 + k), id: 4'(k)});
      tick();
    end
    req_vld = '0;
    a2c_lkp_rdy = 1'b0;
    chk("mid_outstanding", 64'(outstanding), 5);
    void'(c2a_q.pop_back());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_outstanding", 64'(outstanding), 0);
    chk("mid_rst_c2a_vld", 64'(c2a_lkp_vld), 0);
    chk("mid_rst_c2a_info", 64'(c2a_lkp_info), 0);
    chk("mid_rst_c2a_id", 64'(c2a_lkp_req_id), 0);
    chk("mid_rst_rsp_vld", 64'(rsp_vld), 0);
    chk("mid_rst_rsp_rslt", 64'(rsp_rslt), 0);
    chk("mid_rst_err", 64'(err_unalloc), 0);
    a2c_lkp_rdy = 1'b1;
    send_rsp(4'd1, 32'h11);
    tick();
    a2c_lkp_rsp_vld = 1'b0;
    chk("late_rsp_err", 64'(err_unalloc), 1);
    chk("late_rsp_no_vld", 64'(rsp_vld), 0);
    chk("late_rsp_outstanding", 64'(outstanding), 0);
    tick();
    tick();

    chk("c2a_queue_empty", 64'(c2a_q.size()), 0);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lkp_arb_ctrl.md
LKP_ARB_CTRL -- requirements
Module: lkp_arb_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of lookup requesters; ID_W, default 4, req_id width giving 16 outstanding IDs; INFO_W, default 64, lookup info width; RSLT_W, default 32, lookup result width.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_vld  in  NUM_REQ  per-requester lookup request valid
- req_info  in  NUM_REQ*INFO_W  per-requester lookup info; requester i occupies slice i
- req_rdy  out  NUM_REQ  per-requester accept
- c2a_lkp_vld  out  1  lookup request to A
- c2a_lkp_info  out  INFO_W  lookup info to A
- c2a_lkp_req_id  out  ID_W  allocated request ID
- a2c_lkp_rdy  in  1  A accepts request
- a2c_lkp_rsp_vld  in  1  A response valid; no backpressure
- a2c_lkp_rsp_id  in  ID_W  response ID
- a2c_lkp_rslt  in  RSLT_W  lookup result
- rsp_vld  out  NUM_REQ  one-hot response to the owning requester
- rsp_rslt  out  RSLT_W  result for rsp_vld
- rsp_req_id  out  ID_W  ID being returned
- outstanding  out  ID_W+1  count of allocated IDs
- err_unalloc  out  1  sticky flag: response received for an unallocated ID

Function
REQ-003 A request SHALL be accepted (req_vld[i] and req_rdy[i]) only when the output slot is free or draining this cycle (c2a_lkp_vld and a2c_lkp_rdy) and at least one ID is free.
REQ-004 req_rdy SHALL be one-hot or zero, and SHALL be asserted only for the round-robin winner among asserted req_vld.
REQ-005 The round-robin pointer SHALL advance to winner+1 (mod NUM_REQ) only on an accepted request; it SHALL hold otherwise.
REQ-006 On acceptance, the block SHALL allocate the lowest-numbered free ID, mark it busy, and record its owner index.
REQ-007 The accepted request SHALL appear on c2a_lkp_vld/info/req_id in the following cycle (1-cycle latency).
REQ-008 c2a_lkp_info and c2a_lkp_req_id SHALL be held stable while c2a_lkp_vld=1 and a2c_lkp_rdy=0.
REQ-009 Back-to-back acceptance SHALL sustain one request per cycle while a2c_lkp_rdy=1 and IDs remain.
REQ-010 When a2c_lkp_rsp_vld=1 with a busy ID, the block SHALL assert rsp_vld[owner] in the next cycle with rsp_rslt and rsp_req_id registered, and SHALL free the ID in that same next cycle.
REQ-011 A freed ID SHALL be allocatable from the cycle after it is freed; allocation in the response cycle SHALL use the pre-free bitmap.
REQ-012 If a response and an allocation occur in the same cycle, outstanding SHALL be unchanged; otherwise it SHALL change by +1 or -1 respectively.
REQ-013 A response to a free ID SHALL set err_unalloc, SHALL produce no rsp_vld, and SHALL leave the pool unchanged.
REQ-014 With all 2^ID_W IDs busy, req_rdy SHALL be 0 and outstanding SHALL equal 2^ID_W; the output slot SHALL still drain.
REQ-015 Responses SHALL be accepted in any order relative to requests.

Reset
REQ-016 When rst=1 at a clock edge, the following SHALL be cleared: all outputs to 0, the ID pool to all-free, the owner table, the RR pointer to 0, and err_unalloc.
REQ-017 A reset mid-operation SHALL discard in-flight requests and outstanding IDs.
REQ-018 Responses arriving after reset for pre-reset IDs SHALL set err_unalloc.

Structure
REQ-019 The NUM_REQ, ID_W, INFO_W and RSLT_W defaults and the owner-entry typedef SHALL live in c_module_pkg.
REQ-020 Round-robin arbitration SHALL be a sub-module lkp_rr_arb (inputs: request vector, advance; outputs: one-hot grant, index).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single: req_vld[2]=1 with info 0xA5, a2c_lkp_rdy=1 -> next cycle c2a_lkp_vld=1, info 0xA5, req_id 0; then rsp id 0, rslt 0x55 -> next cycle rsp_vld=4'b0100, rsp_rslt=0x55.
- Fairness: all 4 requesters valid continuously, rdy=1 -> grant order 0,1,2,3,0; IDs 0,1,2,3,4.
- Exhaustion: 16 requests issued without response -> outstanding=16 and req_rdy=0; one rsp id 7 -> the next accepted request receives ID 7.
- Stall: a2c_lkp_rdy=0 for 5 cycles -> c2a fields stable; at most one request accepted during the stall.
- Out-of-order and error: responses for IDs 3,0,2 -> routed to their owners; rsp id 9 while free -> err_unalloc=1, no rsp_vld.
- Reset mid-operation: rst asserted with 5 IDs outstanding -> outstanding=0 and all outputs 0; a late rsp id 1 -> err_unalloc=1.
